// File: rtl/sa_autosa_rdma_dmaif_mc.sv
// Multi-channel read DMA interface to a single memory port.
// NCH client request channels are round-robin arbitrated onto one memory
// request register. A tag FIFO of {channel, size} remembers issue order so
// that in-order memory responses can be steered back to the owning client.
// Per-channel outstanding beat counters bound how much each client may
// have in flight.
module sa_autosa_rdma_dmaif_mc #(
  parameter int NCH       = 2,
  parameter int REQ_W     = 47,
  parameter int RSP_W     = 65,
  parameter int TAG_DEPTH = 8,   // power of 2, at least 2
  parameter int MAX_OUT   = 32
) (
  input  logic                 autosa_core_clk,
  input  logic                 autosa_core_rst,
  input  logic [NCH*REQ_W-1:0] dma_rd_req_pd,
  input  logic [NCH-1:0]       dma_rd_req_vld,
  output logic [NCH-1:0]       dma_rd_req_rdy,
  output logic [RSP_W-1:0]     dma_rd_rsp_pd,
  output logic [NCH-1:0]       dma_rd_rsp_vld,
  input  logic [NCH-1:0]       dma_rd_rsp_rdy,
  input  logic [NCH-1:0]       dma_rd_rsp_ram_type,
  input  logic [NCH-1:0]       dma_rd_cdt_lat_fifo_pop,
  output logic [REQ_W-1:0]     mem_rd_req_pd,
  output logic                 mem_rd_req_valid,
  input  logic                 mem_rd_req_ready,
  input  logic [RSP_W-1:0]     mem_rd_rsp_pd,
  input  logic                 mem_rd_rsp_valid,
  output logic                 mem_rd_rsp_ready,
  output logic [NCH-1:0]       mem_rd_cdt_lat_fifo_pop,
  output logic                 rsp_err
);

  localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int SZ_W = 15;
  localparam int AW   = $clog2(TAG_DEPTH);
  localparam int OC_W = $clog2(MAX_OUT + 1);
  localparam int TG_W = CH_W + SZ_W;

  // Tag FIFO: extra pointer MSB distinguishes full from empty
  logic [TG_W-1:0] tag_mem [TAG_DEPTH];
  logic [AW:0]     wr_ptr, rd_ptr;
  logic            tag_empty, tag_full;
  logic [TG_W-1:0] head;
  logic [CH_W-1:0] head_ch;
  logic [SZ_W-1:0] head_sz;

  logic [NCH-1:0][OC_W-1:0] out_beats, out_nxt;
  logic [CH_W-1:0]          rr_ptr, gnt_ch;
  logic                     gnt, can_issue;
  logic [NCH-1:0]           elig;
  logic [REQ_W-1:0]         gnt_pd;
  logic [SZ_W-1:0]          gnt_sz;
  logic [SZ_W-1:0]          beat_cnt;
  logic                     beat_acc, last_beat;

  assign tag_empty = (wr_ptr == rd_ptr);
  assign tag_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head      = tag_mem[rd_ptr[AW-1:0]];
  assign head_ch   = head[TG_W-1:SZ_W];
  assign head_sz   = head[SZ_W-1:0];

  // A channel may be granted only if its whole burst fits under MAX_OUT
  always_comb begin
    elig = '0;
    for (int c = 0; c < NCH; c++) begin
      elig[c] = dma_rd_req_vld[c] && !tag_full &&
                ((int'(out_beats[c]) + int'(dma_rd_req_pd[c*REQ_W + REQ_W - SZ_W +: SZ_W]) + 1) <= MAX_OUT);
    end
  end

  // Round-robin pick starting at rr_ptr; grant only when the output register can take it
  assign can_issue = !mem_rd_req_valid || mem_rd_req_ready;
  always_comb begin
    int  idx;
    logic found;
    idx    = 0;
    found  = 1'b0;
    gnt_ch = '0;
    for (int i = 0; i < NCH; i++) begin
      idx = (int'(rr_ptr) + i) % NCH;
      if (!found && elig[idx]) begin
        found  = 1'b1;
        gnt_ch = CH_W'(idx);
      end
    end
    gnt = found && can_issue;
  end

  assign gnt_pd = dma_rd_req_pd[gnt_ch*REQ_W +: REQ_W];
  assign gnt_sz = gnt_pd[REQ_W-1 -: SZ_W];

  // Ready goes back only to the granted client
  always_comb begin
    dma_rd_req_rdy = '0;
    for (int c = 0; c < NCH; c++)
      dma_rd_req_rdy[c] = gnt && (gnt_ch == CH_W'(c));
  end

  // Request output register: load on grant, clear once drained
  always_ff @(posedge autosa_core_clk) begin
    if (autosa_core_rst) begin
      mem_rd_req_valid <= 1'b0;
    end else if (gnt) begin
      mem_rd_req_pd    <= gnt_pd;
      mem_rd_req_valid <= 1'b1;
    end else if (mem_rd_req_ready) begin
      mem_rd_req_valid <= 1'b0;
    end
  end

  // Priority pointer moves past the last grantee
  always_ff @(posedge autosa_core_clk) begin
    if (autosa_core_rst)
      rr_ptr <= '0;
    else if (gnt)
      rr_ptr <= (int'(gnt_ch) == NCH - 1) ? '0 : gnt_ch + 1'b1;
  end

  // Tag storage write; contents need no reset since pointers gate them
  always_ff @(posedge autosa_core_clk) begin
    if (gnt) tag_mem[wr_ptr[AW-1:0]] <= {gnt_ch, gnt_sz};
  end

  // Tag FIFO pointers: push on grant, pop on the last beat of the head burst
  always_ff @(posedge autosa_core_clk) begin
    if (autosa_core_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (gnt)       wr_ptr <= wr_ptr + 1'b1;
      if (last_beat) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Response steering: zero-latency pass-through to the head channel
  assign dma_rd_rsp_pd    = mem_rd_rsp_pd;
  assign mem_rd_rsp_ready = !tag_empty && dma_rd_rsp_rdy[head_ch];
  assign beat_acc         = mem_rd_rsp_valid && mem_rd_rsp_ready;
  assign last_beat        = beat_acc && (beat_cnt == head_sz);

  always_comb begin
    dma_rd_rsp_vld = '0;
    for (int c = 0; c < NCH; c++)
      dma_rd_rsp_vld[c] = mem_rd_rsp_valid && !tag_empty && (head_ch == CH_W'(c));
  end

  // Beat counter within the head burst
  always_ff @(posedge autosa_core_clk) begin
    if (autosa_core_rst)
      beat_cnt <= '0;
    else if (last_beat)
      beat_cnt <= '0;
    else if (beat_acc)
      beat_cnt <= beat_cnt + 1'b1;
  end

  // Outstanding beats: add burst length on grant, subtract one per returned beat
  always_comb begin
    int v;
    v = 0;
    out_nxt = out_beats;
    for (int c = 0; c < NCH; c++) begin
      v = int'(out_beats[c]);
      if (gnt && gnt_ch == CH_W'(c))      v = v + int'(gnt_sz) + 1;
      if (beat_acc && head_ch == CH_W'(c)) v = v - 1;
      out_nxt[c] = OC_W'(v);
    end
  end

  // Outstanding counter registers
  always_ff @(posedge autosa_core_clk) begin
    if (autosa_core_rst) out_beats <= '0;
    else                 out_beats <= out_nxt;
  end

  // Sticky error: memory returned data with nothing outstanding
  always_ff @(posedge autosa_core_clk) begin
    if (autosa_core_rst)                    rsp_err <= 1'b0;
    else if (mem_rd_rsp_valid && tag_empty) rsp_err <= 1'b1;
  end

  // Credit pop forwarded only for MC-type channels, one cycle late
  always_ff @(posedge autosa_core_clk) begin
    if (autosa_core_rst) mem_rd_cdt_lat_fifo_pop <= '0;
    else                 mem_rd_cdt_lat_fifo_pop <= dma_rd_cdt_lat_fifo_pop & dma_rd_rsp_ram_type;
  end

endmodule

// File: tb/tb_sa_autosa_rdma_dmaif_mc.sv
// Directed bench for sa_autosa_rdma_dmaif_mc with default parameters.
module tb_sa_autosa_rdma_dmaif_mc;
  localparam int NCH = 2, REQ_W = 47, RSP_W = 65;

  logic                 clk = 1'b0, rst;
  logic [NCH*REQ_W-1:0] dma_rd_req_pd;
  logic [NCH-1:0]       dma_rd_req_vld, dma_rd_req_rdy;
  logic [RSP_W-1:0]     dma_rd_rsp_pd;
  logic [NCH-1:0]       dma_rd_rsp_vld, dma_rd_rsp_rdy, ram_type, cdt_pop;
  logic [REQ_W-1:0]     mem_rd_req_pd;
  logic                 mem_rd_req_valid, mem_rd_req_ready;
  logic [RSP_W-1:0]     mem_rd_rsp_pd;
  logic                 mem_rd_rsp_valid, mem_rd_rsp_ready;
  logic [NCH-1:0]       mem_cdt_pop;
  logic                 rsp_err;
  int checks = 0, errors = 0;

  sa_autosa_rdma_dmaif_mc dut (
    .autosa_core_clk(clk), .autosa_core_rst(rst),
    .dma_rd_req_pd(dma_rd_req_pd), .dma_rd_req_vld(dma_rd_req_vld), .dma_rd_req_rdy(dma_rd_req_rdy),
    .dma_rd_rsp_pd(dma_rd_rsp_pd), .dma_rd_rsp_vld(dma_rd_rsp_vld), .dma_rd_rsp_rdy(dma_rd_rsp_rdy),
    .dma_rd_rsp_ram_type(ram_type), .dma_rd_cdt_lat_fifo_pop(cdt_pop),
    .mem_rd_req_pd(mem_rd_req_pd), .mem_rd_req_valid(mem_rd_req_valid), .mem_rd_req_ready(mem_rd_req_ready),
    .mem_rd_rsp_pd(mem_rd_rsp_pd), .mem_rd_rsp_valid(mem_rd_rsp_valid), .mem_rd_rsp_ready(mem_rd_rsp_ready),
    .mem_rd_cdt_lat_fifo_pop(mem_cdt_pop), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct { logic [1:0] cdt; logic [1:0] ram; logic [1:0] exp; } cdt_vec_t;
  cdt_vec_t tv [6];

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [REQ_W-1:0] mk(input int sz, input logic [31:0] a);
    logic [14:0] s;
    s = 15'(sz);
    return {s, a};
  endfunction

  task automatic set_req(input int c, input int sz, input logic [31:0] a);
    dma_rd_req_pd[c*REQ_W +: REQ_W] = mk(sz, a);
  endtask

  initial begin
    int n;
    tv[0] = '{2'b11, 2'b01, 2'b01};
    tv[1] = '{2'b11, 2'b10, 2'b10};
    tv[2] = '{2'b11, 2'b11, 2'b11};
    tv[3] = '{2'b01, 2'b11, 2'b01};
    tv[4] = '{2'b00, 2'b11, 2'b00};
    tv[5] = '{2'b10, 2'b00, 2'b00};

    rst = 1'b1; dma_rd_req_pd = '0; dma_rd_req_vld = '0; dma_rd_rsp_rdy = 2'b11;
    ram_type = '0; cdt_pop = '0; mem_rd_req_ready = 1'b1; mem_rd_rsp_pd = '0; mem_rd_rsp_valid = 1'b0;
    tick(); tick();
    chk("rst_req_valid", mem_rd_req_valid, 0);
    chk("rst_cdt_pop", mem_cdt_pop, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_rsp_ready", mem_rd_rsp_ready, 0);
    rst = 1'b0;
    tick();

    // credit pop table
    for (int i = 0; i < 6; i++) begin
      cdt_pop = tv[i].cdt; ram_type = tv[i].ram;
      tick();
      chk($sformatf("cdt_vec%0d", i), mem_cdt_pop, tv[i].exp);
    end
    cdt_pop = '0; ram_type = '0;

    // both channels size 0 every cycle: alternate grants, continuous valid
    set_req(0, 0, 32'h100); set_req(1, 0, 32'h200); dma_rd_req_vld = 2'b11;
    for (int i = 0; i < 6; i++) begin
      #1 chk($sformatf("rr_rdy%0d", i), dma_rd_req_rdy, (i % 2) ? 2'b10 : 2'b01);
      tick();
      chk($sformatf("rr_valid%0d", i), mem_rd_req_valid, 1);
      chk($sformatf("rr_pd%0d", i), mem_rd_req_pd, (i % 2) ? mk(0, 32'h200) : mk(0, 32'h100));
    end
    dma_rd_req_vld = '0;
    tick();
    chk("rr_valid_drop", mem_rd_req_valid, 0);
    mem_rd_rsp_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      mem_rd_rsp_pd = {1'b1, 64'(i)};
      #1 chk($sformatf("rr_rsp_vld%0d", i), dma_rd_rsp_vld, (i % 2) ? 2'b10 : 2'b01);
      chk($sformatf("rr_rsp_rdy%0d", i), mem_rd_rsp_ready, 1);
      chk($sformatf("rr_rsp_pd%0d", i), dma_rd_rsp_pd, {1'b1, 64'(i)});
      tick();
    end
    mem_rd_rsp_valid = 1'b0;
    #1 chk("rr_drain_empty", mem_rd_rsp_ready, 0);

    // ch0 size 3 -> four beats to ch0, then tag pops
    set_req(0, 3, 32'h300); dma_rd_req_vld = 2'b01;
    #1 chk("b4_rdy", dma_rd_req_rdy, 2'b01);
    tick();
    dma_rd_req_vld = '0;
    chk("b4_req_pd", mem_rd_req_pd, mk(3, 32'h300));
    tick();
    mem_rd_rsp_valid = 1'b1; n = 0;
    for (int i = 0; i < 4; i++) begin
      #1 if (dma_rd_rsp_vld == 2'b01 && mem_rd_rsp_ready) n++;
      tick();
    end
    mem_rd_rsp_valid = 1'b0;
    chk("b4_beats", n, 4);
    #1 chk("b4_popped", mem_rd_rsp_ready, 0);

    // MAX_OUT boundary: 32 beats fit, one more is blocked until a beat returns
    set_req(0, 31, 32'h400); dma_rd_req_vld = 2'b01;
    #1 chk("max_fit", dma_rd_req_rdy, 2'b01);
    tick();
    set_req(0, 0, 32'h410);
    #1 chk("max_block", dma_rd_req_rdy, 2'b00);
    mem_rd_rsp_valid = 1'b1;
    #1 chk("max_rsp_rdy", mem_rd_rsp_ready, 1);
    tick();
    #1 chk("max_release", dma_rd_req_rdy, 2'b01);
    tick();
    dma_rd_req_vld = '0; n = 0;
    for (int i = 0; i < 31; i++) begin
      #1 if (dma_rd_rsp_vld == 2'b01 && mem_rd_rsp_ready) n++;
      tick();
    end
    mem_rd_rsp_valid = 1'b0;
    chk("max_drain_beats", n, 31);
    #1 chk("max_drain_empty", mem_rd_rsp_ready, 0);

    // tag FIFO full: 8 issued, 9th waits for a pop
    set_req(0, 0, 32'h500); dma_rd_req_vld = 2'b01; n = 0;
    for (int i = 0; i < 12; i++) begin
      #1 if (dma_rd_req_rdy[0]) n++;
      tick();
    end
    chk("tag_full_grants", n, 8);
    #1 chk("tag_full_hold", dma_rd_req_rdy, 2'b00);
    mem_rd_rsp_valid = 1'b1;
    tick();
    #1 chk("tag_full_release", dma_rd_req_rdy, 2'b01);
    tick();
    dma_rd_req_vld = '0; n = 0;
    for (int i = 0; i < 7; i++) begin
      #1 if (mem_rd_rsp_ready) n++;
      tick();
    end
    mem_rd_rsp_valid = 1'b0;
    chk("tag_drain_beats", n, 7);
    #1 chk("tag_drain_empty", mem_rd_rsp_ready, 0);

    // ch1 at head with rdy low, ch0 behind: no reordering
    set_req(1, 0, 32'h600); dma_rd_req_vld = 2'b10;
    tick();
    set_req(0, 0, 32'h610); dma_rd_req_vld = 2'b01;
    tick();
    dma_rd_req_vld = '0;
    dma_rd_rsp_rdy = 2'b01; mem_rd_rsp_valid = 1'b1;
    #1 chk("ord_blocked", mem_rd_rsp_ready, 0);
    chk("ord_head_vld", dma_rd_rsp_vld, 2'b10);
    tick();
    chk("ord_still_head", dma_rd_rsp_vld, 2'b10);
    dma_rd_rsp_rdy = 2'b11;
    #1 chk("ord_unblock", mem_rd_rsp_ready, 1);
    tick();
    chk("ord_next_ch0", dma_rd_rsp_vld, 2'b01);
    tick();
    mem_rd_rsp_valid = 1'b0;
    #1 chk("ord_empty", mem_rd_rsp_ready, 0);
    chk("ord_no_err", rsp_err, 0);

    // stalled request held stable, no grant while full, reset discards it
    mem_rd_req_ready = 1'b0;
    set_req(0, 2, 32'h700); dma_rd_req_vld = 2'b01;
    tick();
    set_req(0, 0, 32'h800);
    chk("stall_pd", mem_rd_req_pd, mk(2, 32'h700));
    #1 chk("stall_no_grant", dma_rd_req_rdy, 2'b00);
    tick();
    chk("stall_hold_valid", mem_rd_req_valid, 1);
    chk("stall_hold_pd", mem_rd_req_pd, mk(2, 32'h700));
    dma_rd_req_vld = '0; rst = 1'b1;
    tick();
    rst = 1'b0; mem_rd_req_ready = 1'b1;
    chk("midrst_valid", mem_rd_req_valid, 0);
    chk("midrst_tags", mem_rd_rsp_ready, 0);
    chk("midrst_rsp_vld", dma_rd_rsp_vld, 2'b00);

    // unexpected response -> sticky error
    mem_rd_rsp_valid = 1'b1;
    #1 chk("err_not_accepted", mem_rd_rsp_ready, 0);
    tick();
    mem_rd_rsp_valid = 1'b0;
    chk("err_set", rsp_err, 1);
    tick(); tick();
    chk("err_sticky", rsp_err, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("err_cleared", rsp_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
